rf_writeback_queue: RTL and testbench
=====================================

// Module: rf_writeback_queue
// PURPOSE
//  Write-side client of the 32x32 register file: collects results from the ALU and the
//  load unit, buffers them in an in-order FIFO and drains one per cycle into the single
//  register-file write port (wb_we/wb_addr/wb_data -> Reg_Write/Write_Reg/Write_Data).
//  Also answers decode-stage "is rsN pending?" queries with the youngest buffered value
//  for forwarding, so reads never see stale data while a write waits in the queue.
// PARAMETERS
//  DATA_W  32  result / register data width
//  ADDR_W  5   register index width (32 registers)
//  DEPTH   4   FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1        clock; all state updates on posedge
//  rst        in   1        synchronous, active-high reset
//  alu_valid  in   1        ALU result offered
//  alu_ready  out  1        ALU result accepted this cycle when alu_valid && alu_ready
//  alu_rd     in   ADDR_W   ALU destination register
//  alu_data   in   DATA_W   ALU result
//  mem_valid  in   1        load result offered
//  mem_ready  out  1        load result accepted when mem_valid && mem_ready
//  mem_rd     in   ADDR_W   load destination register
//  mem_data   in   DATA_W   load data
//  drain_en   in   1        1 = write port available this cycle; 0 = hold head
//  wb_we      out  1        register-file write enable
//  wb_addr    out  ADDR_W   register-file write address
//  wb_data    out  DATA_W   register-file write data
//  chk_rs1    in   ADDR_W   decode source 1 query
//  chk_rs2    in   ADDR_W   decode source 2 query
//  rs1_hit    out  1        chk_rs1 has a buffered pending write
//  rs1_fwd    out  DATA_W   youngest buffered value for chk_rs1 (0 when !rs1_hit)
//  rs2_hit    out  1        as rs1_hit for chk_rs2
//  rs2_fwd    out  DATA_W   as rs1_fwd for chk_rs2
//  count      out  ADDR_W   occupied entries, 0..DEPTH
//  full       out  1        count == DEPTH
//  empty      out  1        count == 0
// BEHAVIOUR
//  - Reset: rd/wr pointers 0, count 0, all entry valid bits 0; hence empty=1, full=0,
//    wb_we=0, wb_addr=0, wb_data=0, rs*_hit=0, rs*_fwd=0. rst mid-operation discards all
//    buffered entries; nothing is written to the register file in the reset cycle.
//  - Enqueue: at most one per cycle. mem has priority over ALU.
//    mem_ready = !full; alu_ready = !full && !mem_valid. Ready depends on registered
//    state only (no same-cycle dequeue bypass): full queue refuses even if draining.
//  - rd == 0: handshake completes normally but no entry is stored (r0 stays 0).
//  - Drain: wb_we = !empty && drain_en; wb_addr/wb_data = head entry (combinational from
//    registered head; 0 when empty). Head pops on the posedge where wb_we=1, the same
//    edge the register file samples the write.
//  - Latency: result accepted at edge N is head-visible in cycle N+1 if queue was empty;
//    earliest register-file write at edge N+1.
//  - Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is separate (no
//    pointer-equality ambiguity).
//  - Forwarding: combinational compare of chk_rsN against all valid entries; youngest
//    matching entry (closest to wr_ptr) wins. chk_rsN == 0 never hits. An entry popped
//    at edge N is no longer a hit in cycle N+1 (the register file now holds it).
//  - No internal FSM beyond FIFO occupancy; states EMPTY / PARTIAL / FULL derived from count.
// TESTING
//  1 rst, then alu x5=0xAAAA_0001 one cycle, drain_en=1 -> next cycle wb_we=1 addr=5
//    data=0xAAAA_0001; following cycle empty=1, wb_we=0.
//  2 mem and alu valid same cycle (mem x3=0x33, alu x4=0x44) -> mem accepted, alu_ready=0;
//    alu accepted next cycle; writes drain in order x3 then x4.
//  3 drain_en=0, enqueue 4 results -> full=1, count=4, both readies 0; 5th held off;
//    raise drain_en -> 4 writes in FIFO order, pointers wrap, count returns to 0.
//  4 enqueue x7=0x1 then x7=0x2 with drain_en=0, chk_rs1=7 -> rs1_hit=1, rs1_fwd=0x2;
//    chk_rs2=0 -> rs2_hit=0, rs2_fwd=0.
//  5 alu offers rd=0 data=0xDEAD -> alu_ready=1, count stays 0, no wb_we ever.
//  6 queue holding 3 entries, assert rst one cycle -> next cycle empty=1, wb_we=0,
//    no hits; the discarded entries are never written.

Source files
------------

// File: rtl/rf_writeback_queue.sv
// In-order write-back FIFO between the ALU/load results and the single register-file write port.
// It also forwards the youngest buffered value to the decode-stage source-operand queries.
module rf_writeback_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              drain_en,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] chk_rs1,
    input  logic [ADDR_W-1:0] chk_rs2,
    output logic              rs1_hit,
    output logic [DATA_W-1:0] rs1_fwd,
    output logic              rs2_hit,
    output logic [DATA_W-1:0] rs2_fwd,
    output logic [ADDR_W-1:0] count,
    output logic              full,
    output logic              empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ent_valid [DEPTH];
    logic [ADDR_W-1:0] ent_rd    [DEPTH];
    logic [DATA_W-1:0] ent_data  [DEPTH];

    logic              mem_fire, alu_fire, enq_store, deq;
    logic [ADDR_W-1:0] enq_rd;
    logic [DATA_W-1:0] enq_data;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = ADDR_W'(count_q);
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;

    assign mem_fire  = mem_valid && mem_ready;
    assign alu_fire  = alu_valid && alu_ready;
    assign enq_rd    = mem_fire ? mem_rd : alu_rd;
    assign enq_data  = mem_fire ? mem_data : alu_data;
    // Writes to r0 complete the handshake but are dropped here.
    assign enq_store = (mem_fire || alu_fire) && (enq_rd != '0);
    assign deq       = drain_en && !empty && !rst;

    assign wb_we   = deq;
    assign wb_addr = empty ? '0 : ent_rd[rd_ptr_q];
    assign wb_data = empty ? '0 : ent_data[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (enq_store) wr_ptr_d = wr_ptr_q + PW'(1);
        if (deq)       rd_ptr_d = rd_ptr_q + PW'(1);
        case ({enq_store, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic              valid_q;
            logic [ADDR_W-1:0] rd_q;
            logic [DATA_W-1:0] data_q;

            // Set and clear never target the same slot: that needs an empty or full queue.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                end else if (enq_store && wr_ptr_q == PW'(gi)) begin
                    valid_q <= 1'b1;
                    rd_q    <= enq_rd;
                    data_q  <= enq_data;
                end else if (deq && rd_ptr_q == PW'(gi)) begin
                    valid_q <= 1'b0;
                end
            end

            assign ent_valid[gi] = valid_q;
            assign ent_rd[gi]    = rd_q;
            assign ent_data[gi]  = data_q;
        end
    endgenerate

    logic [ADDR_W-1:0] chk_addr [2];
    assign chk_addr[0] = chk_rs1;
    assign chk_addr[1] = chk_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic              hit_c;
            logic [DATA_W-1:0] fwd_c;
            logic [PW-1:0]     idx;

            // Walk oldest to youngest so the last match (youngest) wins.
            always_comb begin
                hit_c = 1'b0;
                fwd_c = '0;
                idx   = rd_ptr_q;
                for (int i = 0; i < DEPTH; i++) begin
                    idx = rd_ptr_q + PW'(i);
                    if (ent_valid[idx] && ent_rd[idx] == chk_addr[gi] && chk_addr[gi] != '0) begin
                        hit_c = 1'b1;
                        fwd_c = ent_data[idx];
                    end
                end
            end
        end
    endgenerate

    assign rs1_hit = g_fwd[0].hit_c;
    assign rs1_fwd = g_fwd[0].fwd_c;
    assign rs2_hit = g_fwd[1].hit_c;
    assign rs2_fwd = g_fwd[1].fwd_c;

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue: ordering, back-pressure, forwarding, r0 drop, reset flush.
module tb_rf_writeback_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, mem_valid, mem_ready, drain_en;
    logic [4:0]  alu_rd, mem_rd, chk_rs1, chk_rs2, wb_addr, count;
    logic [31:0] alu_data, mem_data, wb_data, rs1_fwd, rs2_fwd;
    logic        wb_we, rs1_hit, rs2_hit, full, empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_writeback_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .drain_en(drain_en),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
        .rs1_hit(rs1_hit), .rs1_fwd(rs1_fwd), .rs2_hit(rs2_hit), .rs2_fwd(rs2_fwd),
        .count(count), .full(full), .empty(empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; drain_en = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        chk_rs1 = 5'd5; chk_rs2 = 5'd0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_wb_we", 32'(wb_we), 32'd0);
        chk("rst_wb_addr", 32'(wb_addr), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_rs1_hit", 32'(rs1_hit), 32'd0);
        chk("rst_rs1_fwd", rs1_fwd, 32'd0);

        // 1: single ALU result drains the next cycle
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hAAAA_0001;
        #1;
        chk("t1_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        #1;
        chk("t1_wb_we", 32'(wb_we), 32'd1);
        chk("t1_wb_addr", 32'(wb_addr), 32'd5);
        chk("t1_wb_data", wb_data, 32'hAAAA_0001);
        chk("t1_rs1_hit", 32'(rs1_hit), 32'd1);
        chk("t1_rs1_fwd", rs1_fwd, 32'hAAAA_0001);
        tick();
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_wb_we_off", 32'(wb_we), 32'd0);
        chk("t1_rs1_hit_off", 32'(rs1_hit), 32'd0);

        // 2: mem wins over ALU, then in-order drain
        drain_en = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h33;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        #1;
        chk("t2_mem_ready", 32'(mem_ready), 32'd1);
        chk("t2_alu_ready", 32'(alu_ready), 32'd0);
        tick();
        mem_valid = 1'b0;
        #1;
        chk("t2_count1", 32'(count), 32'd1);
        chk("t2_alu_ready2", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("t2_count2", 32'(count), 32'd2);
        drain_en = 1'b1;
        #1;
        chk("t2_wb_we0", 32'(wb_we), 32'd1);
        chk("t2_wb_addr0", 32'(wb_addr), 32'd3);
        chk("t2_wb_data0", wb_data, 32'h33);
        tick();
        chk("t2_wb_addr1", 32'(wb_addr), 32'd4);
        chk("t2_wb_data1", wb_data, 32'h44);
        tick();
        chk("t2_empty", 32'(empty), 32'd1);

        // 3: fill to full, no dequeue bypass, drain with pointer wrap
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'h100 + 32'(i);
            tick();
        end
        alu_rd = 5'd14; alu_data = 32'h104; mem_valid = 1'b1; mem_rd = 5'd15;
        #1;
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_count", 32'(count), 32'd4);
        chk("t3_alu_ready", 32'(alu_ready), 32'd0);
        chk("t3_mem_ready", 32'(mem_ready), 32'd0);
        mem_valid = 1'b0;
        drain_en = 1'b1;
        #1;
        chk("t3_alu_ready_drain", 32'(alu_ready), 32'd0);
        chk("t3_wb_addr0", 32'(wb_addr), 32'd10);
        chk("t3_wb_data0", wb_data, 32'h100);
        tick();
        alu_valid = 1'b0;
        chk("t3_count_after", 32'(count), 32'd3);
        for (int i = 1; i < 4; i++) begin
            #1;
            chk("t3_wb_we", 32'(wb_we), 32'd1);
            chk("t3_wb_addr", 32'(wb_addr), 32'(10 + i));
            chk("t3_wb_data", wb_data, 32'h100 + 32'(i));
            tick();
        end
        chk("t3_empty", 32'(empty), 32'd1);
        chk("t3_count0", 32'(count), 32'd0);

        // 4: forwarding returns the youngest of two writes to x7
        drain_en = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h1;
        tick();
        alu_data = 32'h2;
        tick();
        alu_valid = 1'b0;
        chk_rs1 = 5'd7; chk_rs2 = 5'd0;
        #1;
        chk("t4_rs1_hit", 32'(rs1_hit), 32'd1);
        chk("t4_rs1_fwd", rs1_fwd, 32'h2);
        chk("t4_rs2_hit", 32'(rs2_hit), 32'd0);
        chk("t4_rs2_fwd", rs2_fwd, 32'd0);
        chk_rs2 = 5'd7;
        #1;
        chk("t4_rs2_fwd7", rs2_fwd, 32'h2);
        drain_en = 1'b1;
        tick();
        chk("t4_hit_after_pop1", 32'(rs1_hit), 32'd1);
        chk("t4_fwd_after_pop1", rs1_fwd, 32'h2);
        tick();
        chk("t4_hit_after_pop2", 32'(rs1_hit), 32'd0);
        chk("t4_fwd_after_pop2", rs1_fwd, 32'd0);

        // 5: rd == 0 is accepted but never stored
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD; chk_rs1 = 5'd0;
        #1;
        chk("t5_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_wb_we", 32'(wb_we), 32'd0);
        tick();
        chk("t5_wb_we2", 32'(wb_we), 32'd0);

        // 6: reset flushes buffered entries without writing them
        drain_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = 32'h200 + 32'(i);
            tick();
        end
        alu_valid = 1'b0;
        chk("t6_count3", 32'(count), 32'd3);
        chk_rs1 = 5'd20;
        rst = 1'b1; drain_en = 1'b1;
        #1;
        chk("t6_wb_we_in_rst", 32'(wb_we), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_count0", 32'(count), 32'd0);
        chk("t6_wb_we", 32'(wb_we), 32'd0);
        chk("t6_rs1_hit", 32'(rs1_hit), 32'd0);
        tick();
        chk("t6_wb_we2", 32'(wb_we), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
